// File: rtl/updown_seq_if.sv
// Control and counter-side signals of the up/down sweep sequencer.
// The master modport is the environment: the host that issues commands, plus the counter readback.
interface updown_seq_if;
  logic       start;
  logic       abort;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] sweeps;
  logic [3:0] cnt_dout;
  logic       cnt_LTn;
  logic       cnt_Upn_down;
  logic [3:0] cnt_Load;
  logic       busy;
  logic       done;
  logic       err;
  logic       aborted;
  logic [3:0] sweep_cnt;

  modport master (
    output start, abort, lo, hi, sweeps, cnt_dout,
    input  cnt_LTn, cnt_Upn_down, cnt_Load, busy, done, err, aborted, sweep_cnt
  );

  modport slave (
    input  start, abort, lo, hi, sweeps, cnt_dout,
    output cnt_LTn, cnt_Upn_down, cnt_Load, busy, done, err, aborted, sweep_cnt
  );
endinterface

// File: rtl/updown_seq.sv
// Ping-pong sweep sequencer for a 4-bit up/down counter with synchronous load.
// The counter is frozen by a synchronous load whenever no sweep is running.
//
// state | meaning
// IDLE  | counter held at hold value, waiting for start
// LOAD  | loading lo bound into the counter
// UP    | counting up toward hi
// DOWN  | counting down toward lo
// DONE  | one-cycle completion, counter held
module updown_seq (
  input  logic               clk,
  input  logic               arstn,
  updown_seq_if.slave        bus
);

  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] lo_q, lo_d;
  logic [3:0] hi_q, hi_d;
  logic [3:0] sweeps_q, sweeps_d;
  logic [3:0] sweep_cnt_q, sweep_cnt_d;
  logic [3:0] hold_q, hold_d;
  logic       err_q, err_d;
  logic       aborted_q, aborted_d;

  logic       cnt_ltn;
  logic       cnt_updn;
  logic [3:0] cnt_load;
  logic       done;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
      hold_q      <= '0;
      err_q       <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      sweeps_q    <= sweeps_d;
      sweep_cnt_q <= sweep_cnt_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      aborted_q   <= aborted_d;
    end
  end

  // Counter controls are combinational on cnt_dout so the turn happens on the bound itself.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sweeps_d    = sweeps_q;
    sweep_cnt_d = sweep_cnt_q;
    hold_d      = hold_q;
    err_d       = 1'b0;
    aborted_d   = 1'b0;
    cnt_ltn     = 1'b0;
    cnt_updn    = 1'b0;
    cnt_load    = hold_q;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          lo_d        = bus.lo;
          hi_d        = bus.hi;
          sweeps_d    = bus.sweeps;
          sweep_cnt_d = '0;
          if ((bus.lo >= bus.hi) || (bus.sweeps == 4'd0)) err_d   = 1'b1;
          else                                            state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_load = lo_q;
        state_d  = UP;
      end
      UP: begin
        cnt_ltn = 1'b1;
        if (bus.cnt_dout == hi_q) begin
          cnt_updn = 1'b1;
          state_d  = DOWN;
        end
      end
      DOWN: begin
        cnt_ltn  = 1'b1;
        cnt_updn = 1'b1;
        if (bus.cnt_dout == lo_q) begin
          sweep_cnt_d = sweep_cnt_q + 4'd1;
          if ((sweep_cnt_q + 4'd1) == sweeps_q) begin
            cnt_ltn  = 1'b0;
            cnt_updn = 1'b0;
            cnt_load = lo_q;
            hold_d   = lo_q;
            state_d  = DONE;
          end else begin
            cnt_updn = 1'b0;
            state_d  = UP;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort outranks every transition, including the final DOWN -> DONE step.
    if ((state_q != IDLE) && bus.abort) begin
      cnt_ltn     = 1'b0;
      cnt_updn    = 1'b0;
      cnt_load    = bus.cnt_dout;
      hold_d      = bus.cnt_dout;
      sweep_cnt_d = sweep_cnt_q;
      done        = 1'b0;
      aborted_d   = 1'b1;
      state_d     = IDLE;
    end
  end

  assign bus.cnt_LTn      = cnt_ltn;
  assign bus.cnt_Upn_down = cnt_updn;
  assign bus.cnt_Load     = cnt_load;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done;
  assign bus.err          = err_q;
  assign bus.aborted      = aborted_q;
  assign bus.sweep_cnt    = sweep_cnt_q;

endmodule

// File: tb/tb_updown_seq.sv
// Directed bench for updown_seq driving a behavioural 4-bit up/down counter with sync load.
module tb_updown_seq;

  logic clk   = 1'b0;
  logic arstn = 1'b1;

  updown_seq_if bus();

  updown_seq dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counter being sequenced: LTn=0 loads, otherwise Upn_down selects direction.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)            bus.cnt_dout <= 4'd0;
    else if (!bus.cnt_LTn) bus.cnt_dout <= bus.cnt_Load;
    else if (bus.cnt_Upn_down) bus.cnt_dout <= bus.cnt_dout - 4'd1;
    else                   bus.cnt_dout <= bus.cnt_dout + 4'd1;
  end

  int         errors = 0;
  int         checks = 0;
  logic [3:0] traj[$];
  int         bc;
  int         dc;
  bit         tmo;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [3:0] l, input logic [3:0] h, input logic [3:0] s,
                           input logic ab);
    bus.lo = l; bus.hi = h; bus.sweeps = s; bus.start = 1'b1; bus.abort = ab;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
  endtask

  // Runs until busy drops; traj[k] is cnt_dout after edge E1+k.
  task automatic collect();
    bc = 0; dc = 0; traj.delete(); tmo = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (!bus.busy) begin
        tmo = 1'b0;
        break;
      end
      bc++;
      if (bus.done) dc++;
      step();
      traj.push_back(bus.cnt_dout);
    end
  endtask

  task automatic test_reset();
    #2 arstn = 1'b0;
    #2;
    checks++;
    if ({bus.cnt_LTn, bus.cnt_Upn_down, bus.busy, bus.done, bus.err, bus.aborted} !== 6'b0 ||
        bus.cnt_Load !== 4'd0 || bus.sweep_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ltn=%0b updn=%0b load=%0d busy=%0b done=%0b err=%0b ab=%0b sc=%0d want all 0",
               bus.cnt_LTn, bus.cnt_Upn_down, bus.cnt_Load, bus.busy, bus.done, bus.err,
               bus.aborted, bus.sweep_cnt);
    end
    step(); step();
    arstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (bus.cnt_dout !== 4'd0 || bus.busy !== 1'b0 || bus.cnt_LTn !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: got dout=%0d busy=%0b ltn=%0b want 0 0 0",
                 i, bus.cnt_dout, bus.busy, bus.cnt_LTn);
      end
    end
  endtask

  task automatic test_single_sweep();
    logic [3:0] exp_t [9] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd5, 4'd4, 4'd3, 4'd3, 4'd3};
    start_cmd(4'd3, 4'd6, 4'd1, 1'b0);
    collect();
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL single_timeout: got busy stuck want idle"); end
    // LOAD + 2DS+1 counting cycles + DONE
    checks++;
    if (bc !== 9) begin errors++; $display("FAIL single_busy: got %0d want 9", bc); end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL single_done: got %0d want 1", dc); end
    checks++;
    if (traj.size() !== 9) begin
      errors++; $display("FAIL single_len: got %0d want 9", traj.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        checks++;
        if (traj[k] !== exp_t[k]) begin
          errors++; $display("FAIL single_dout[%0d]: got %0d want %0d", k, traj[k], exp_t[k]);
        end
      end
    end
    checks++;
    if (bus.sweep_cnt !== 4'd1) begin
      errors++; $display("FAIL single_sweep_cnt: got %0d want 1", bus.sweep_cnt);
    end
  endtask

  task automatic test_reject();
    start_cmd(4'd5, 4'd5, 4'd2, 1'b0);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.sweep_cnt !== 4'd0) begin
      errors++; $display("FAIL reject_eq: got err=%0b busy=%0b sc=%0d want 1 0 0",
                         bus.err, bus.busy, bus.sweep_cnt);
    end
    step();
    checks++;
    if (bus.err !== 1'b0 || bus.cnt_dout !== 4'd3) begin
      errors++; $display("FAIL reject_eq_after: got err=%0b dout=%0d want 0 3", bus.err, bus.cnt_dout);
    end
    start_cmd(4'd2, 4'd5, 4'd0, 1'b0);
    checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reject_zero: got err=%0b busy=%0b want 1 0", bus.err, bus.busy);
    end
    step();
    checks++;
    if (bus.err !== 1'b0 || bus.cnt_dout !== 4'd3 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reject_zero_after: got err=%0b dout=%0d busy=%0b want 0 3 0",
                         bus.err, bus.cnt_dout, bus.busy);
    end
  endtask

  task automatic test_full_range();
    int bad;
    int e;
    start_cmd(4'd0, 4'd15, 4'd2, 1'b0);
    collect();
    checks++;
    if (tmo !== 1'b0 || bc !== 63) begin
      errors++; $display("FAIL full_busy: got %0d (timeout=%0b) want 63", bc, tmo);
    end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL full_done: got %0d want 1", dc); end
    checks++;
    if (traj.size() !== 63) begin
      errors++; $display("FAIL full_len: got %0d want 63", traj.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 63; k++) begin
        e = (k <= 15) ? k : (k <= 30) ? 30 - k : (k <= 45) ? k - 30 : (k <= 60) ? 60 - k : 0;
        if (traj[k] !== 4'(e)) begin
          if (bad == 0) $display("FAIL full_traj[%0d]: got %0d want %0d", k, traj[k], e);
          bad++;
        end
      end
      if (bad != 0) errors++;
      checks++;
      if (traj[15] !== 4'd15 || traj[30] !== 4'd0 || traj[45] !== 4'd15 || traj[60] !== 4'd0) begin
        errors++; $display("FAIL full_turns: got %0d %0d %0d %0d want 15 0 15 0",
                           traj[15], traj[30], traj[45], traj[60]);
      end
    end
    checks++;
    if (bus.sweep_cnt !== 4'd2) begin
      errors++; $display("FAIL full_sweep_cnt: got %0d want 2", bus.sweep_cnt);
    end
  endtask

  task automatic test_abort();
    int seen_done;
    logic [3:0] exp_t [5] = '{4'd4, 4'd5, 4'd4, 4'd4, 4'd4};
    seen_done = 0;
    start_cmd(4'd2, 4'd9, 4'd3, 1'b0);
    // Sweep 1 ends at E1+14, hi again at E1+21, 7 on the way down at E1+23.
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus.done) seen_done++;
    end
    checks++;
    if (bus.cnt_dout !== 4'd7 || bus.busy !== 1'b1 || bus.cnt_Upn_down !== 1'b1) begin
      errors++; $display("FAIL abort_pre: got dout=%0d busy=%0b updn=%0b want 7 1 1",
                         bus.cnt_dout, bus.busy, bus.cnt_Upn_down);
    end
    bus.abort = 1'b1;
    #1;
    checks++;
    if (bus.cnt_LTn !== 1'b0 || bus.cnt_Load !== 4'd7) begin
      errors++; $display("FAIL abort_decode: got ltn=%0b load=%0d want 0 7", bus.cnt_LTn, bus.cnt_Load);
    end
    step();
    bus.abort = 1'b0;
    if (bus.done) seen_done++;
    checks++;
    if (bus.cnt_dout !== 4'd7 || bus.aborted !== 1'b1 || bus.busy !== 1'b0 || bus.sweep_cnt !== 4'd1) begin
      errors++; $display("FAIL abort_post: got dout=%0d ab=%0b busy=%0b sc=%0d want 7 1 0 1",
                         bus.cnt_dout, bus.aborted, bus.busy, bus.sweep_cnt);
    end
    step(); step();
    checks++;
    if (bus.aborted !== 1'b0 || bus.cnt_dout !== 4'd7 || seen_done !== 0) begin
      errors++; $display("FAIL abort_hold: got ab=%0b dout=%0d done_seen=%0d want 0 7 0",
                         bus.aborted, bus.cnt_dout, seen_done);
    end
    start_cmd(4'd4, 4'd5, 4'd1, 1'b1);
    checks++;
    if (bus.busy !== 1'b1 || bus.aborted !== 1'b0) begin
      errors++; $display("FAIL restart_start_wins: got busy=%0b ab=%0b want 1 0", bus.busy, bus.aborted);
    end
    collect();
    checks++;
    if (tmo !== 1'b0 || bc !== 5 || dc !== 1 || traj.size() !== 5) begin
      errors++; $display("FAIL restart_run: got busy=%0d done=%0d len=%0d want 5 1 5", bc, dc, traj.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (traj[k] !== exp_t[k]) begin
          errors++; $display("FAIL restart_dout[%0d]: got %0d want %0d", k, traj[k], exp_t[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_t [5] = '{4'd1, 4'd2, 4'd1, 4'd1, 4'd1};
    start_cmd(4'd1, 4'd8, 4'd1, 1'b0);
    step(); step(); step();
    checks++;
    if (bus.busy !== 1'b1 || bus.cnt_dout !== 4'd3) begin
      errors++; $display("FAIL midreset_pre: got busy=%0b dout=%0d want 1 3", bus.busy, bus.cnt_dout);
    end
    arstn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.cnt_dout !== 4'd0 || bus.cnt_LTn !== 1'b0 || bus.cnt_Load !== 4'd0 ||
        bus.cnt_Upn_down !== 1'b0 || bus.sweep_cnt !== 4'd0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL midreset_vals: got busy=%0b dout=%0d ltn=%0b load=%0d updn=%0b sc=%0d done=%0b want all 0",
                         bus.busy, bus.cnt_dout, bus.cnt_LTn, bus.cnt_Load, bus.cnt_Upn_down,
                         bus.sweep_cnt, bus.done);
    end
    #3 arstn = 1'b1;
    step();
    start_cmd(4'd1, 4'd2, 4'd1, 1'b0);
    collect();
    checks++;
    if (tmo !== 1'b0 || bc !== 5 || dc !== 1 || traj.size() !== 5) begin
      errors++; $display("FAIL midreset_run: got busy=%0d done=%0d len=%0d want 5 1 5", bc, dc, traj.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (traj[k] !== exp_t[k]) begin
          errors++; $display("FAIL midreset_dout[%0d]: got %0d want %0d", k, traj[k], exp_t[k]);
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.lo = 4'd0; bus.hi = 4'd0; bus.sweeps = 4'd0;
    test_reset();
    test_single_sweep();
    test_reject();
    test_full_range();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
